// File: rtl/bt_cmd_pkg.sv
// Shared constants for the RN-52 command sender: command ROM, address map and FSM state types.
package bt_cmd_pkg;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   localparam logic [4:0] CMD_I2S_ADDR  = 5'd0;
   localparam logic [3:0] CMD_I2S_LEN   = 4'd6;
   localparam logic [4:0] CMD_NAME_ADDR = 5'd6;
   localparam logic [3:0] CMD_NAME_LEN  = 4'd10;
   localparam logic [4:0] CMD_NEXT_ADDR = 5'd16;
   localparam logic [3:0] CMD_NEXT_LEN  = 4'd4;
   localparam logic [4:0] CMD_PREV_ADDR = 5'd20;
   localparam logic [3:0] CMD_PREV_LEN  = 4'd4;

   // "S|,01" CR, "S-,$2G1K$" CR, "AT+" CR, "AT-" CR, then zero fill
   localparam logic [7:0] CMD_ROM [32] = '{
      8'h53, 8'h7C, 8'h2C, 8'h30, 8'h31, CR,
      8'h53, 8'h2D, 8'h2C, 8'h24, 8'h32, 8'h47, 8'h31, 8'h4B, 8'h24, CR,
      8'h41, 8'h54, 8'h2B, CR,
      8'h41, 8'h54, 8'h2D, CR,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

endpackage

// File: rtl/bt_cmd_sender_if.sv
// Command request handshake between the Bluetooth interface FSM and the command sender.
interface bt_cmd_sender_if;
   logic       send;
   logic [4:0] cmd_start;
   logic [3:0] cmd_len;
   logic       busy;

   modport master (output send, output cmd_start, output cmd_len, input busy);
   modport slave (input send, input cmd_start, input cmd_len, output busy);
endinterface

// File: rtl/bt_uart_rx.sv
// RN-52 UART receiver: synchronizes RX, frames 8N1 bytes and pulses on the response terminator.
module bt_uart_rx
   import bt_cmd_pkg::*;
#(
   parameter int unsigned BAUD_DIV  = 434,
   parameter logic [7:0]  RESP_CHAR = 8'h0A
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_i,
   output logic resp_rcvd_o
);

   localparam int unsigned CntW = $clog2(BAUD_DIV);
   localparam logic [CntW-1:0] BitEnd  = CntW'(BAUD_DIV - 1);
   localparam logic [CntW-1:0] HalfEnd = CntW'(BAUD_DIV / 2 - 1);

   rx_state_e       state_q, state_d;
   logic            sync1_q, sync2_q, prev_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      data_q, data_d;
   logic            resp_q, resp_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RxIdle;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         cnt_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         resp_q  <= resp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CntW'(1);
      bit_d   = bit_q;
      data_d  = data_q;
      resp_d  = 1'b0;
      unique case (state_q)
         RxIdle: begin
            cnt_d = '0;
            if (!sync2_q && prev_q) state_d = RxStart;
         end
         RxStart: begin
            // A start bit that is high again at mid-bit was a glitch
            if (cnt_q == HalfEnd) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = sync2_q ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (cnt_q == BitEnd) begin
               cnt_d  = '0;
               data_d = {sync2_q, data_q[7:1]};
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RxStop;
            end
         end
         RxStop: begin
            if (cnt_q == BitEnd) begin
               cnt_d = '0;
               if (sync2_q) begin
                  state_d = RxIdle;
                  resp_d  = (data_q == RESP_CHAR);
               end else begin
                  state_d = RxWait;
               end
            end
         end
         RxWait: begin
            cnt_d = '0;
            if (sync2_q) state_d = RxIdle;
         end
         default: state_d = RxIdle;
      endcase
   end

   assign resp_rcvd_o = resp_q;

endmodule

// File: rtl/bt_cmd_sender.sv
// RN-52 command transmitter: serializes a ROM command slice as 8N1 frames and detects responses.
module bt_cmd_sender
   import bt_cmd_pkg::*;
#(
   parameter int unsigned BAUD_DIV  = 434,
   parameter logic [7:0]  RESP_CHAR = 8'h0A
) (
   input  logic           clk,
   input  logic           rst_n,
   bt_cmd_sender_if.slave cmd,
   output logic           TX,
   input  logic           RX,
   output logic           resp_rcvd
);

   localparam int unsigned CntW = $clog2(BAUD_DIV);
   localparam logic [CntW-1:0] BitEnd = CntW'(BAUD_DIV - 1);

   tx_state_e       state_q, state_d;
   logic [4:0]      addr_q, addr_d;
   logic [3:0]      rem_q, rem_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            bit_end;

   assign bit_end = (cnt_q == BitEnd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TxIdle;
         addr_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      cnt_d   = bit_end ? '0 : cnt_q + CntW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      unique case (state_q)
         TxIdle: begin
            cnt_d = '0;
            if (cmd.send && (cmd.cmd_len != 4'd0)) begin
               addr_d  = cmd.cmd_start;
               rem_d   = cmd.cmd_len;
               shift_d = CMD_ROM[addr_d];
               state_d = TxStart;
            end
         end
         TxStart: begin
            if (bit_end) begin
               bit_d   = '0;
               state_d = TxData;
            end
         end
         TxData: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = TxStop;
            end
         end
         TxStop: begin
            // Next byte starts with no idle gap; address wraps 31 -> 0
            if (bit_end) begin
               rem_d  = rem_q - 4'd1;
               addr_d = addr_q + 5'd1;
               if (rem_q == 4'd1) begin
                  state_d = TxIdle;
               end else begin
                  shift_d = CMD_ROM[addr_d];
                  state_d = TxStart;
               end
            end
         end
         default: state_d = TxIdle;
      endcase
   end

   always_comb begin
      TX = 1'b1;
      unique case (state_q)
         TxStart: TX = 1'b0;
         TxData:  TX = shift_q[0];
         default: TX = 1'b1;
      endcase
   end

   assign cmd.busy = (state_q != TxIdle);

   bt_uart_rx #(
      .BAUD_DIV  (BAUD_DIV),
      .RESP_CHAR (RESP_CHAR)
   ) u_rx (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_i        (RX),
      .resp_rcvd_o (resp_rcvd)
   );

endmodule

// File: tb/tb_bt_cmd_sender.sv
// Directed bench for bt_cmd_sender with BAUD_DIV=8: TX framing, send filtering, RX response detect.
module tb_bt_cmd_sender;

   localparam int unsigned BAUD = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic tx;
   logic resp;

   bt_cmd_sender_if cmd_if ();

   bt_cmd_sender #(
      .BAUD_DIV  (BAUD),
      .RESP_CHAR (8'h0A)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd_if),
      .TX        (tx),
      .RX        (rx),
      .resp_rcvd (resp)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int busy_cnt = 0;
   int tx_low_cnt = 0;
   int resp_cnt = 0;
   int resp_cyc = -1;
   int last_stop_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (cmd_if.busy === 1'b1) busy_cnt++;
      if (tx === 1'b0) tx_low_cnt++;
      if (resp === 1'b1) begin
         resp_cnt++;
         resp_cyc = cyc;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   task automatic send_cmd(input logic [4:0] s, input logic [3:0] l);
      cmd_if.send      = 1'b1;
      cmd_if.cmd_start = s;
      cmd_if.cmd_len   = l;
      @(negedge clk);
      cmd_if.send = 1'b0;
   endtask

   // Frame bits sampled mid-bit: fr[0]=start, fr[8:1]=data LSB first, fr[9]=stop
   task automatic capture_frame(output logic [9:0] fr);
      int n;
      n  = 0;
      fr = 'x;
      while (tx !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (tx !== 1'b0) return;
      repeat (BAUD / 2) @(negedge clk);
      fr[0] = tx;
      for (int i = 1; i < 10; i++) begin
         repeat (BAUD) @(negedge clk);
         fr[i] = tx;
      end
      repeat (BAUD / 2) @(negedge clk);
   endtask

   task automatic drive_rx(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BAUD) @(negedge clk);
      end
      last_stop_cyc = cyc;
      rx = stop;
      repeat (BAUD) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      cmd_if.send      = 1'b0;
      cmd_if.cmd_start = '0;
      cmd_if.cmd_len   = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
      total++;
      if (cmd_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", cmd_if.busy); end
      total++;
      if (resp !== 1'b0) begin bad++; $display("FAIL reset_resp: got %b want 0", resp); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_next_track();
      logic [7:0] exp [4];
      logic [9:0] fr;
      exp = '{8'h41, 8'h54, 8'h2B, 8'h0D};
      busy_cnt = 0;
      send_cmd(5'd16, 4'd4);
      total++;
      if (tx !== 1'b0) begin bad++; $display("FAIL first_start_bit: got %b want 0", tx); end
      for (int i = 0; i < 4; i++) begin
         capture_frame(fr);
         total++;
         if (fr !== {1'b1, exp[i], 1'b0}) begin
            bad++;
            $display("FAIL next_frame%0d: got %b want %b", i, fr, {1'b1, exp[i], 1'b0});
         end
      end
      total++;
      if (cmd_if.busy !== 1'b0) begin bad++; $display("FAIL next_busy_end: got %b want 0", cmd_if.busy); end
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL next_tx_idle: got %b want 1", tx); end
      repeat (20) @(negedge clk);
      total++;
      if (busy_cnt != 320) begin bad++; $display("FAIL next_busy_len: got %0d want 320", busy_cnt); end
   endtask

   task automatic test_rx_resp();
      logic [7:0] frames [5];
      frames = '{8'h43, 8'h4D, 8'h44, 8'h0D, 8'h0A};
      resp_cnt = 0;
      resp_cyc = -1;
      for (int i = 0; i < 5; i++) drive_rx(frames[i], 1'b1);
      repeat (30) @(negedge clk);
      total++;
      if (resp_cnt != 1) begin bad++; $display("FAIL rx_pulse_count: got %0d want 1", resp_cnt); end
      total++;
      if (resp_cyc < last_stop_cyc || resp_cyc > last_stop_cyc + int'(BAUD)) begin
         bad++;
         $display("FAIL rx_pulse_pos: got cycle %0d want %0d..%0d", resp_cyc, last_stop_cyc,
                  last_stop_cyc + int'(BAUD));
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [10];
      logic [9:0] fr;
      exp = '{8'h53, 8'h2D, 8'h2C, 8'h24, 8'h32, 8'h47, 8'h31, 8'h4B, 8'h24, 8'h0D};
      busy_cnt = 0;
      send_cmd(5'd6, 4'd10);
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               capture_frame(fr);
               total++;
               if (fr !== {1'b1, exp[i], 1'b0}) begin
                  bad++;
                  $display("FAIL name_frame%0d: got %b want %b", i, fr, {1'b1, exp[i], 1'b0});
               end
            end
         end
         begin
            repeat (49) @(negedge clk);
            send_cmd(5'd16, 4'd4);
            repeat (349) @(negedge clk);
            send_cmd(5'd20, 4'd4);
         end
      join
      repeat (20) @(negedge clk);
      total++;
      if (busy_cnt != 800) begin bad++; $display("FAIL name_busy_len: got %0d want 800", busy_cnt); end

      // send sampled on the edge where busy falls must be dropped
      busy_cnt = 0;
      send_cmd(5'd16, 4'd4);
      repeat (319) @(negedge clk);
      send_cmd(5'd20, 4'd4);
      repeat (40) @(negedge clk);
      total++;
      if (busy_cnt != 320) begin bad++; $display("FAIL busy_edge_send: got %0d want 320", busy_cnt); end

      busy_cnt   = 0;
      tx_low_cnt = 0;
      send_cmd(5'd0, 4'd0);
      repeat (100) @(negedge clk);
      total++;
      if (busy_cnt != 0) begin bad++; $display("FAIL len0_busy: got %0d want 0", busy_cnt); end
      total++;
      if (tx_low_cnt != 0) begin bad++; $display("FAIL len0_tx: got %0d want 0", tx_low_cnt); end
   endtask

   task automatic test_addr_wrap();
      logic [7:0] exp [4];
      logic [9:0] fr;
      exp = '{8'h00, 8'h00, 8'h53, 8'h7C};
      send_cmd(5'd30, 4'd4);
      for (int i = 0; i < 4; i++) begin
         capture_frame(fr);
         total++;
         if (fr !== {1'b1, exp[i], 1'b0}) begin
            bad++;
            $display("FAIL wrap_frame%0d: got %b want %b", i, fr, {1'b1, exp[i], 1'b0});
         end
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_rx_errors();
      resp_cnt = 0;
      drive_rx(8'h0A, 1'b0);
      repeat (16) @(negedge clk);
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      total++;
      if (resp_cnt != 0) begin bad++; $display("FAIL rx_err_nopulse: got %0d want 0", resp_cnt); end
      drive_rx(8'h0A, 1'b1);
      repeat (20) @(negedge clk);
      total++;
      if (resp_cnt != 1) begin bad++; $display("FAIL rx_err_recover: got %0d want 1", resp_cnt); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp [4];
      logic [9:0] fr;
      exp = '{8'h41, 8'h54, 8'h2D, 8'h0D};
      send_cmd(5'd0, 4'd6);
      repeat (30) @(negedge clk);
      // mid data bit 2 of 'S' (0x53), which is a 0
      total++;
      if (tx !== 1'b0) begin bad++; $display("FAIL mid_tx_before: got %b want 0", tx); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL mid_tx_async: got %b want 1", tx); end
      total++;
      if (cmd_if.busy !== 1'b0) begin bad++; $display("FAIL mid_busy_async: got %b want 0", cmd_if.busy); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send_cmd(5'd20, 4'd4);
      for (int i = 0; i < 4; i++) begin
         capture_frame(fr);
         total++;
         if (fr !== {1'b1, exp[i], 1'b0}) begin
            bad++;
            $display("FAIL prev_frame%0d: got %b want %b", i, fr, {1'b1, exp[i], 1'b0});
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_next_track();
      test_rx_resp();
      test_back_to_back();
      test_addr_wrap();
      test_rx_errors();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
